// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter with a one-word holding register.
// A word queued in hold during transmission follows the current word with no idle gap.
module piso_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             C,
  input  logic             CLR_N,
  input  logic [WIDTH-1:0] PI,
  input  logic             PI_VALID,
  output logic             PI_READY,
  output logic             SO,
  output logic             SO_VALID,
  output logic             SO_LAST,
  output logic             BUSY
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, SHIFT_QUEUED} state_t;

  state_t           r_state, w_nstate;
  logic [WIDTH-1:0] r_sh, w_sh;
  logic [WIDTH-1:0] r_hold, w_hold;
  logic [CW-1:0]    r_cnt, w_cnt;
  logic             w_accept, w_last;
  logic [WIDTH-1:0] w_shifted;

  assign PI_READY = CLR_N & (r_state != SHIFT_QUEUED);
  assign w_accept = PI_VALID & PI_READY;
  assign w_last   = (r_cnt == LAST_IDX);

  // Shift toward the output end, filling the vacated bit with 0
  generate
    if (MSB_FIRST) begin : g_msb
      assign w_shifted = {r_sh[WIDTH-2:0], 1'b0};
      assign SO        = r_sh[WIDTH-1];
    end else begin : g_lsb
      assign w_shifted = {1'b0, r_sh[WIDTH-1:1]};
      assign SO        = r_sh[0];
    end
  endgenerate

  assign SO_VALID = (r_state != IDLE);
  assign SO_LAST  = SO_VALID & w_last;
  assign BUSY     = SO_VALID;

  always_ff @(posedge C or negedge CLR_N) begin
    if (!CLR_N) begin
      r_state <= IDLE;
      r_sh    <= '0;
      r_hold  <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_nstate;
      r_sh    <= w_sh;
      r_hold  <= w_hold;
      r_cnt   <= w_cnt;
    end
  end

  always_comb begin
    w_nstate = r_state;
    w_sh     = r_sh;
    w_hold   = r_hold;
    w_cnt    = r_cnt;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_sh     = PI;
          w_cnt    = '0;
          w_nstate = SHIFT;
        end
      end
      SHIFT: begin
        if (!w_last) begin
          w_sh  = w_shifted;
          w_cnt = r_cnt + CW'(1);
          if (w_accept) begin
            w_hold   = PI;
            w_nstate = SHIFT_QUEUED;
          end
        end else if (w_accept) begin
          // Last bit with an empty hold: load straight into sh, no gap
          w_sh  = PI;
          w_cnt = '0;
        end else begin
          w_sh     = '0;
          w_cnt    = '0;
          w_nstate = IDLE;
        end
      end
      SHIFT_QUEUED: begin
        if (!w_last) begin
          w_sh  = w_shifted;
          w_cnt = r_cnt + CW'(1);
        end else begin
          w_sh     = r_hold;
          w_cnt    = '0;
          w_nstate = SHIFT;
        end
      end
      default: begin
        w_nstate = IDLE;
        w_sh     = '0;
        w_cnt    = '0;
      end
    endcase
  end
endmodule
